// File: rtl/seq_timer_pkg.sv
// Shared definitions for the serial-programmed delay timer: one-hot state
// indices for the default 4-bit delay field and the one-hot legality check.
package seq_timer_pkg;

   localparam int S       = 0;
   localparam int S1      = S + 1;
   localparam int S11     = S1 + 1;
   localparam int S110    = S11 + 1;
   localparam int B0      = S110 + 1;
   localparam int B1      = B0 + 1;
   localparam int B2      = B1 + 1;
   localparam int B3      = B2 + 1;
   localparam int COUNT   = B3 + 1;
   localparam int WAIT    = COUNT + 1;
   localparam int STATE_W = WAIT + 1;

   // Widest state vector onehot_ok() accepts; narrower vectors are zero-extended.
   localparam int MAX_STATE_W = 32;

   function automatic logic onehot_ok(input logic [MAX_STATE_W-1:0] state);
      return $onehot(state);
   endfunction

endpackage

// File: rtl/seq_timer_unit_cnt.sv
// Per-unit cycle counter: counts 0..CYCLES_PER_UNIT-1 while enabled and
// flags the last cycle of each unit; held at zero whenever disabled.
module seq_timer_unit_cnt #(
   parameter int CYCLES_PER_UNIT = 1000
) (
   input  logic clk,
   input  logic aresetn,
   input  logic en,
   output logic wrap
);

   localparam int               CNT_W = $clog2(CYCLES_PER_UNIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES_PER_UNIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!en || wrap) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_timer_ctrl.sv
// Sequencing controller for the serial-programmed delay timer: finds 1101,
// shifts in the delay, counts (delay+1) units, then holds done until ack.
module seq_timer_ctrl
   import seq_timer_pkg::*;
#(
   parameter int CYCLES_PER_UNIT = 1000,
   parameter int DELAY_W         = 4
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               data,
   input  logic               ack,
   output logic               shift_ena,
   output logic               counting,
   output logic               done,
   output logic [DELAY_W-1:0] remaining
);

   // The package indices assume a 4-bit delay; the B chain, and every index
   // above it, stretches with DELAY_W.
   localparam int B_LEN   = B3 - B0 + 1;
   localparam int I_COUNT = COUNT + DELAY_W - B_LEN;
   localparam int I_WAIT  = I_COUNT + (WAIT - COUNT);
   localparam int SW      = STATE_W + DELAY_W - B_LEN;

   logic [SW-1:0]      state_q;
   logic [SW-1:0]      state_d;
   logic [DELAY_W-1:0] delay_q;
   logic [DELAY_W-1:0] delay_d;

   logic state_legal;
   logic b_any;
   logic in_count;
   logic in_wait;
   logic unit_wrap;
   logic delay_zero;
   logic count_last;

   assign state_legal = onehot_ok(MAX_STATE_W'(state_q));
   assign b_any       = |state_q[I_COUNT-1:B0];
   assign in_count    = state_q[I_COUNT];
   assign in_wait     = state_q[I_WAIT];
   assign delay_zero  = (delay_q == '0);
   assign count_last  = in_count & unit_wrap & delay_zero;

   // A corrupted vector with the COUNT bit set must not keep the counter running.
   seq_timer_unit_cnt #(
      .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
   ) u_unit_cnt (
      .clk    (clk),
      .aresetn(aresetn),
      .en     (in_count & state_legal),
      .wrap   (unit_wrap)
   );

   // NOTE: every variable gets a default before any branch so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = '0;
      delay_d = delay_q;
      if (!state_legal) begin
         state_d[S] = 1'b1;
         delay_d    = '0;
      end else begin
         state_d[S]    = (~data & (state_q[S] | state_q[S1] | state_q[S110]))
                       | (in_wait & ack);
         state_d[S1]   = state_q[S] & data;
         state_d[S11]  = (state_q[S1] | state_q[S11]) & data;
         state_d[S110] = state_q[S11] & ~data;
         state_d[B0]   = state_q[S110] & data;

         state_d[I_COUNT-1:B0+1] = state_q[I_COUNT-2:B0];
         state_d[I_COUNT]        = state_q[I_COUNT-1] | (in_count & ~count_last);
         state_d[I_WAIT]         = count_last | (in_wait & ~ack);

         // The bit seen in B0 ends up as the MSB after DELAY_W shifts.
         if (b_any) begin
            delay_d = {delay_q[DELAY_W-2:0], data};
         end else if (in_count && unit_wrap && !delay_zero) begin
            delay_d = delay_q - DELAY_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= SW'(1) << S;
         delay_q <= '0;
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
      end
   end

   // Outputs decode raw state bits, so an illegal vector shows through unmasked.
   assign shift_ena = b_any;
   assign counting  = in_count;
   assign done      = in_wait;
   assign remaining = in_count ? delay_q : '0;

endmodule

// File: doc/seq_timer_ctrl.md
Name: seq_timer_ctrl

Overview:
- Controller that sequences a complete serial-programmed delay timer.
- Searches the serial input for the start pattern 1101, then shifts in a 4-bit delay (MSB first).
- Runs the count datapath for (delay+1)*CYCLES_PER_UNIT cycles, raises done and holds it until the user acks.
- Owns the one-hot state register, the delay shift/down-count register and the per-unit cycle counter; it sits above the next-state equations used elsewhere in the FSM family.

Parameters:
- CYCLES_PER_UNIT, 1000, cycles per delay unit; must be >= 2.
- DELAY_W, 4, width of the serial delay field; also the number of shift cycles.

Ports:
- clk  in  1  rising-edge clock.
- aresetn  in  1  asynchronous, active-low reset.
- data  in  1  serial input: pattern bits, then delay bits.
- ack  in  1  user acknowledge; sampled only in WAIT.
- shift_ena  out  1  high while delay bits are being captured.
- counting  out  1  high in COUNT.
- done  out  1  high in WAIT.
- remaining  out  DELAY_W  current delay value in COUNT; 0 in all other states.

Behaviour:
- State register: 10-bit one-hot. Bit order: S, S1, S11, S110, B0, B1, B2, B3, COUNT, WAIT.
- Reset (aresetn low, asynchronous): state = S only. Delay register = 0, unit counter = 0. All outputs 0. Deassertion takes effect on the next clk edge.
- Pattern search, overlapping:
  - S: data=1 -> S1, else S.
  - S1: data=1 -> S11, else S.
  - S11: data=1 -> S11, else S110.
  - S110: data=1 -> B0, else S.
- B0..B3:
  - Unconditional advance B0->B1->B2->B3->COUNT.
  - shift_ena=1 in each of these states.
  - Each edge: delay <= {delay[DELAY_W-2:0], data}, so the bit present in B0 becomes the MSB.
  - B-state count equals DELAY_W. With DELAY_W != 4, the B chain length scales; the one-hot width becomes 6+DELAY_W.
- COUNT:
  - counting=1; remaining=delay.
  - Unit counter increments each cycle from 0.
  - At unit counter == CYCLES_PER_UNIT-1:
    - if delay==0 -> WAIT;
    - else delay <= delay-1 and unit counter <= 0.
  - Total cycles in COUNT = (D+1)*CYCLES_PER_UNIT exactly. D=0 gives CYCLES_PER_UNIT cycles.
  - data is ignored in COUNT.
- WAIT:
  - done=1; stays in WAIT while ack=0.
  - ack=1 -> S on the next edge; done drops in that same cycle.
  - The pattern search restarts fresh; data during WAIT is not pre-matched.
- ack outside WAIT: ignored.
- data outside S..B3: ignored.
- Entering COUNT: unit counter is 0. The unit counter is cleared in every state other than COUNT.
- Illegal state vector (not one-hot, from SEU etc.): next state = S; delay and unit counter cleared. Outputs in that cycle are decoded from the raw bits: counting = state[COUNT], done = state[WAIT], shift_ena = OR of B bits.
- All outputs are pure decodes of registered state/delay: no combinational path from data or ack to outputs.
- Reset mid-COUNT or mid-WAIT: immediate return to S, outputs 0.

Decomposition:
- Shared package seq_timer_pkg holds:
  - state index localparams S, S1, S11, S110, B0..B3, COUNT, WAIT;
  - STATE_W;
  - function onehot_ok(state) for the illegal-state check.
- One sub-module: seq_timer_unit_cnt.
  - Parameterised by CYCLES_PER_UNIT; width $clog2(CYCLES_PER_UNIT).
  - Inputs: clk, aresetn, en (state==COUNT).
  - Output: wrap (counter == CYCLES_PER_UNIT-1).
  - The top-level FSM and delay register consume wrap.

Test Plan (CYCLES_PER_UNIT=4 unless noted):
- Reset: aresetn low mid-stream -> state S, shift_ena/counting/done=0, remaining=0 asynchronously, before the next clk edge.
- Start pattern:
  - data 1,1,0,1 then 0,1,0,1 (D=5) -> shift_ena high exactly 4 cycles;
  - counting high exactly 24 cycles; remaining shows 5,4,3,2,1,0, each for 4 cycles;
  - then done=1.
- Overlap and false starts: data 1,1,1,0,1 then 0,0,0,0 -> B0 entered after the 5th bit; counting high 4 cycles. Data 1,0,1,1,0,0 -> never leaves the search states.
- Ack:
  - done held 10 cycles with ack=0;
  - ack=1 one cycle -> done=0 next edge;
  - a following 1,1,0,1 restarts;
  - ack pulses during COUNT have no effect.
- Max delay with CYCLES_PER_UNIT=1000: delay 1111 -> counting high exactly 16000 cycles, remaining wraps 15..0 with no underflow.
- Illegal state: force state to 10'b0000000011 -> next edge state = S, delay = 0.
